// File: rtl/mod_updown_counter.sv
// Up/down modulo counter with synchronous load, programmable upper limit and
// selectable wrap/saturate behaviour at the 0 and max_val limits.
module mod_updown_counter #(
  parameter int WIDTH    = 16,
  parameter bit SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;
  logic             wrap_reg, wrap_next;

  always_comb begin
    q_next    = q_reg;
    tc_next   = tc_reg;
    wrap_next = 1'b0;
    if (load) begin
      q_next  = (load_val > max_val) ? max_val : load_val;
      tc_next = 1'b0;
    end else if (en) begin
      if (up_dn) begin
        // >= rather than == so a max_val lowered below q still terminates
        if (q_reg >= max_val) begin
          if (SAT_MODE) begin
            q_next = max_val;
          end else begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end else begin
          q_next = q_reg + 1'b1;
        end
        tc_next = (q_next == max_val);
      end else begin
        if (q_reg != '0) begin
          q_next = q_reg - 1'b1;
        end else if (SAT_MODE) begin
          q_next = '0;
        end else begin
          q_next    = max_val;
          wrap_next = 1'b1;
        end
        tc_next = (q_next == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg    <= '0;
      tc_reg   <= 1'b0;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      tc_reg   <= tc_next;
      wrap_reg <= wrap_next;
    end
  end

  assign q    = q_reg;
  assign tc   = tc_reg;
  assign wrap = wrap_reg;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench: three counters (4-bit wrap, 4-bit saturate, 16-bit wrap)
// share control inputs; a rule-level model predicts every cycle's outputs.
module tb_mod_updown_counter;

  logic        clk;
  logic        reset_n, en, up_dn, load;
  logic [3:0]  load_val4, max_val4;
  logic [15:0] load_val16, max_val16;
  logic [3:0]  q0, q1;
  logic [15:0] q2;
  logic        tc0, tc1, tc2, wrap0, wrap1, wrap2;

  mod_updown_counter #(.WIDTH(4), .SAT_MODE(1'b0)) dut_w4_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val4), .max_val(max_val4), .q(q0), .tc(tc0), .wrap(wrap0));

  mod_updown_counter #(.WIDTH(4), .SAT_MODE(1'b1)) dut_w4_sat (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val4), .max_val(max_val4), .q(q1), .tc(tc1), .wrap(wrap1));

  mod_updown_counter #(.WIDTH(16), .SAT_MODE(1'b0)) dut_w16_wrap (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val16), .max_val(max_val16), .q(q2), .tc(tc2), .wrap(wrap2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][15:0] q;
    logic [2:0]       tc;
    logic [2:0]       wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_q[3];
  bit   m_tc[3];
  bit   m_wrap[3];
  bit   stim_done = 1'b0;

  logic [2:0][15:0] act_q;
  logic [2:0]       act_tc, act_wrap;
  assign act_q[0]  = {12'd0, q0};
  assign act_q[1]  = {12'd0, q1};
  assign act_q[2]  = q2;
  assign act_tc    = {tc2, tc1, tc0};
  assign act_wrap  = {wrap2, wrap1, wrap0};

  // Drive one cycle of stimulus and queue what each counter must show after it
  task automatic step(input bit rn, input bit ld, input bit e, input bit ud,
                      input logic [3:0] lv4, input logic [3:0] mv4,
                      input logic [15:0] lv16, input logic [15:0] mv16);
    exp_t x;
    int lv, mv;
    bit sat;
    @(negedge clk);
    reset_n = rn; load = ld; en = e; up_dn = ud;
    load_val4 = lv4; max_val4 = mv4; load_val16 = lv16; max_val16 = mv16;
    for (int i = 0; i < 3; i++) begin
      lv  = (i == 2) ? int'(lv16) : int'(lv4);
      mv  = (i == 2) ? int'(mv16) : int'(mv4);
      sat = (i == 1);
      if (!rn) begin
        m_q[i] = 0; m_tc[i] = 0; m_wrap[i] = 0;
      end else if (ld) begin
        m_q[i] = (lv < mv) ? lv : mv; m_tc[i] = 0; m_wrap[i] = 0;
      end else if (e) begin
        m_wrap[i] = 0;
        if (ud) begin
          if (m_q[i] < mv) m_q[i] = m_q[i] + 1;
          else if (sat) m_q[i] = mv;
          else begin m_q[i] = 0; m_wrap[i] = 1; end
          m_tc[i] = (m_q[i] == mv);
        end else begin
          if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
          else if (sat) m_q[i] = 0;
          else begin m_q[i] = mv; m_wrap[i] = 1; end
          m_tc[i] = (m_q[i] == 0);
        end
      end else begin
        m_wrap[i] = 0;
      end
      x.q[i]    = 16'(m_q[i]);
      x.tc[i]   = m_tc[i];
      x.wrap[i] = m_wrap[i];
    end
    sb.push_back(x);
  endtask

  // Monitor: the counters present a result every cycle, one edge after stimulus
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
          checks += 3;
          if (act_q[i] !== x.q[i]) begin
            errors++;
            $display("FAIL q[dut%0d] t=%0t actual=%h required=%h", i, $time, act_q[i], x.q[i]);
          end
          if (act_tc[i] !== x.tc[i]) begin
            errors++;
            $display("FAIL tc[dut%0d] t=%0t actual=%b required=%b", i, $time, act_tc[i], x.tc[i]);
          end
          if (act_wrap[i] !== x.wrap[i]) begin
            errors++;
            $display("FAIL wrap[dut%0d] t=%0t actual=%b required=%b", i, $time, act_wrap[i], x.wrap[i]);
          end
        end
        $display("cycle t=%0t q=%h/%h/%h tc=%b wrap=%b", $time, q0, q1, q2, act_tc, act_wrap);
      end
    end
  end

  initial begin
    logic [3:0]  mv4, lv4;
    logic [15:0] mv16, lv16;
    reset_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0;
    load_val4 = '0; max_val4 = '0; load_val16 = '0; max_val16 = '0;

    // reset dominates load and en
    repeat (2) step(0, 1, 1, 1, 4'd5, 4'd9, 16'h1234, 16'hFFFF);
    // wrap-mode count 0..9..2; 16-bit counter runs alongside
    repeat (12) step(1, 0, 1, 1, 4'd0, 4'd9, 16'h0, 16'hFFFF);
    // load 2 then count down past 0
    step(1, 1, 0, 0, 4'd2, 4'd15, 16'h0002, 16'hFFFF);
    repeat (4) step(1, 0, 1, 0, 4'd0, 4'd15, 16'h0, 16'hFFFF);
    // load clamped to max_val with en high, then one up edge
    step(1, 1, 1, 1, 4'd12, 4'd7, 16'h000C, 16'h0007);
    step(1, 0, 1, 1, 4'd0, 4'd7, 16'h0, 16'h0007);
    // max_val lowered below q while counting up
    step(1, 1, 0, 1, 4'd7, 4'd10, 16'h0007, 16'h000A);
    step(1, 0, 1, 1, 4'd0, 4'd10, 16'h0, 16'h000A);
    step(1, 0, 1, 1, 4'd0, 4'd5, 16'h0, 16'h0005);
    step(1, 0, 1, 1, 4'd0, 4'd5, 16'h0, 16'h0005);
    // full-range 16-bit rollover then hold
    step(1, 1, 0, 1, 4'd14, 4'd15, 16'hFFFE, 16'hFFFF);
    repeat (2) step(1, 0, 1, 1, 4'd0, 4'd15, 16'h0, 16'hFFFF);
    repeat (3) step(1, 0, 0, 1, 4'd0, 4'd15, 16'h0, 16'hFFFF);
    // max_val = 0 in both directions
    repeat (2) step(1, 0, 1, 1, 4'd0, 4'd0, 16'h0, 16'h0);
    repeat (2) step(1, 0, 1, 0, 4'd0, 4'd0, 16'h0, 16'h0);
    // mid-count reset, then resume
    step(1, 1, 0, 1, 4'd6, 4'd9, 16'h0006, 16'h0009);
    step(0, 1, 1, 1, 4'd3, 4'd9, 16'h0003, 16'h0009);
    step(1, 0, 1, 1, 4'd0, 4'd9, 16'h0, 16'h0009);

    mv4 = 4'd9; mv16 = 16'hFFFF;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) mv4 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: mv16 = 16'h0000;
          1: mv16 = 16'hFFFF;
          2: mv16 = 16'($urandom_range(1, 12));
          default: mv16 = 16'($urandom);
        endcase
      end
      lv4  = 4'($urandom_range(0, 15));
      lv16 = ($urandom_range(0, 1) == 1) ? 16'($urandom) : (mv16 - 16'($urandom_range(0, 2)));
      step($urandom_range(0, 49) != 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           lv4, mv4, lv16, mv16);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
